// File: rtl/rob_multi_pkg.sv
// -----------------------------------------------------------------------------
// rob_multi_pkg
//   Shared sizing for the multi-lane reorder buffer: default geometry, the
//   payload width derived from the physical-register address width, and
//   helpers for index and lane-count widths.
// -----------------------------------------------------------------------------
package rob_multi_pkg;

    // Physical register address width; the payload carries the old alias pair
    // plus a flag saying whether the destination alias is meaningful.
    localparam int PR_ADDR_W       = 5;
    localparam int ROB_DATA_WIDTH  = 2 * PR_ADDR_W + 1;

    localparam int ROB_PUSH_WIDTH  = 4;
    localparam int ROB_POP_WIDTH   = 3;
    localparam int ROB_CMPLT_PORTS = 3;   // alu, mem, term
    localparam int ROB_ELEMENTS    = 15;

    // Entry index width for a buffer of the given depth.
    function automatic int rob_idx_w(input int elements);
        return (elements > 1) ? $clog2(elements) : 1;
    endfunction

    // Width of a "how many lanes" count that must be able to hold 0..lanes.
    function automatic int cnt_w(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

    localparam int ROB_IDX_W = rob_idx_w(ROB_ELEMENTS);

endpackage

// File: rtl/rob_wrap_add.sv
// -----------------------------------------------------------------------------
// rob_wrap_add
//   Combinational modular adder: sum = (idx + k) mod ELEMENTS.
//   The wrap is a single compare-and-subtract, so k must not exceed ELEMENTS.
//   Works for any depth, including non-powers of two.
// Ports:
//   idx  in   IDX_W  starting index (0..ELEMENTS-1)
//   k    in   K_W    increment (0..ELEMENTS)
//   sum  out  IDX_W  wrapped result
// -----------------------------------------------------------------------------
module rob_wrap_add
    import rob_multi_pkg::*;
#(
    parameter  int ELEMENTS = ROB_ELEMENTS,
    parameter  int K_W      = 1,
    localparam int IDX_W    = rob_idx_w(ELEMENTS)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [K_W-1:0]   k,
    output logic [IDX_W-1:0] sum
);

    localparam int SUM_W = ((IDX_W > K_W) ? IDX_W : K_W) + 1;

    logic [SUM_W-1:0] raw;

    always_comb begin
        raw = SUM_W'(idx) + SUM_W'(k);
        if (raw >= SUM_W'(ELEMENTS)) begin
            raw = raw - SUM_W'(ELEMENTS);
        end
    end

    assign sum = IDX_W'(raw);

endmodule

// File: rtl/rob_multi.sv
// -----------------------------------------------------------------------------
// rob_multi
//   Circular reorder buffer holding old physical aliases from decode to commit.
//   Up to PUSH_WIDTH in-order allocations and POP_WIDTH in-order commits per
//   cycle, with CMPLT_PORTS independent completion ports.
//   Optional tail squash (macro ROB_FLUSH_EN): kills every entry younger than
//   flush_idx and rewinds the tail; without the macro flush/flush_idx are
//   ignored.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   din/din_valid     allocation payloads and lane valids (lane 0 oldest)
//   din_ready_ct      lanes that may be accepted this cycle
//   entry_nums        index each lane receives if pushed this cycle
//   dout/dout_valid_ct head payloads and count of committable head entries
//   dout_ready_ct     consumer capacity this cycle
//   completed/cmplt_valid  completion index and strobe per port
//   flush/flush_idx   squash request and youngest surviving entry
//   count             occupied entries
// -----------------------------------------------------------------------------
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter  int DATA_WIDTH  = ROB_DATA_WIDTH,
    parameter  int PUSH_WIDTH  = ROB_PUSH_WIDTH,
    parameter  int POP_WIDTH   = ROB_POP_WIDTH,
    parameter  int CMPLT_PORTS = ROB_CMPLT_PORTS,
    parameter  int ELEMENTS    = ROB_ELEMENTS,
    localparam int IDX_W       = rob_idx_w(ELEMENTS),
    localparam int PUSH_CNT_W  = cnt_w(PUSH_WIDTH),
    localparam int POP_CNT_W   = cnt_w(POP_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0] din,
    input  logic [PUSH_WIDTH-1:0]            din_valid,
    output logic [PUSH_CNT_W-1:0]            din_ready_ct,
    output logic [PUSH_WIDTH*IDX_W-1:0]      entry_nums,
    output logic [POP_WIDTH*DATA_WIDTH-1:0]  dout,
    output logic [POP_CNT_W-1:0]             dout_valid_ct,
    input  logic [POP_CNT_W-1:0]             dout_ready_ct,
    input  logic [CMPLT_PORTS*IDX_W-1:0]     completed,
    input  logic [CMPLT_PORTS-1:0]           cmplt_valid,
    input  logic                             flush,
    input  logic [IDX_W-1:0]                 flush_idx,
    output logic [IDX_W:0]                   count
);

    localparam int CNT_W = IDX_W + 1;

    logic [ELEMENTS-1:0]   valid_q, done_q, valid_d, done_d;
    logic [DATA_WIDTH-1:0] payload_q [ELEMENTS];
    logic [IDX_W-1:0]      head_q, tail_q, head_d, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [IDX_W-1:0]      push_idx [PUSH_WIDTH];
    logic [IDX_W-1:0]      pop_idx  [POP_WIDTH];
    logic [IDX_W-1:0]      head_adv, tail_adv;
    logic [PUSH_CNT_W-1:0] push_n;
    logic [POP_CNT_W-1:0]  pop_n;
    logic                  flush_active;

    // Per-lane indices, wrapped within the same cycle.
    for (genvar i = 0; i < PUSH_WIDTH; i++) begin : g_push_idx
        rob_wrap_add #(.ELEMENTS(ELEMENTS), .K_W(CNT_W)) u_add (
            .idx(tail_q), .k(CNT_W'(i)), .sum(push_idx[i])
        );
        assign entry_nums[i*IDX_W +: IDX_W] = push_idx[i];
    end

    for (genvar j = 0; j < POP_WIDTH; j++) begin : g_pop_idx
        rob_wrap_add #(.ELEMENTS(ELEMENTS), .K_W(CNT_W)) u_add (
            .idx(head_q), .k(CNT_W'(j)), .sum(pop_idx[j])
        );
    end

    rob_wrap_add #(.ELEMENTS(ELEMENTS), .K_W(POP_CNT_W)) u_head_adv (
        .idx(head_q), .k(pop_n), .sum(head_adv)
    );

    rob_wrap_add #(.ELEMENTS(ELEMENTS), .K_W(PUSH_CNT_W)) u_tail_adv (
        .idx(tail_q), .k(push_n), .sum(tail_adv)
    );

`ifdef ROB_FLUSH_EN
    logic [IDX_W-1:0]    flush_tail;
    logic [CNT_W-1:0]    flush_count;
    logic [ELEMENTS-1:0] keep_mask;

    rob_wrap_add #(.ELEMENTS(ELEMENTS), .K_W(1)) u_flush_tail (
        .idx(flush_idx), .k(1'b1), .sum(flush_tail)
    );

    // Distance of idx behind base, modulo ELEMENTS: 0 = oldest entry.
    function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] base);
        logic [CNT_W-1:0] diff;
        diff = CNT_W'(idx) - CNT_W'(base);
        if (idx < base) begin
            diff = diff + CNT_W'(ELEMENTS);
        end
        return IDX_W'(diff);
    endfunction

    // Survivors are those no younger than flush_idx, judged by age from head.
    always_comb begin
        logic [IDX_W-1:0] flush_age;
        keep_mask    = '0;
        flush_active = flush;
        flush_age    = age_of(flush_idx, head_q);
        flush_count  = CNT_W'(flush_age) + CNT_W'(1);
        for (int e = 0; e < ELEMENTS; e++) begin
            keep_mask[e] = (age_of(IDX_W'(e), head_q) <= flush_age);
        end
    end
`else
    logic unused_flush;
    assign flush_active = 1'b0;
    assign unused_flush = ^{flush, flush_idx};
`endif

    // Push acceptance depends only on the registered count, so a same-cycle
    // pop never widens the allocation window.
    always_comb begin
        logic [CNT_W-1:0]      free_slots;
        logic [PUSH_CNT_W-1:0] lead;
        logic                  stop;
        // NOTE: every output of a combinational block gets a value on entry, so
        // no path leaves it unassigned and no latch is inferred.
        free_slots   = CNT_W'(ELEMENTS) - count_q;
        din_ready_ct = (free_slots >= CNT_W'(PUSH_WIDTH)) ? PUSH_CNT_W'(PUSH_WIDTH)
                                                          : PUSH_CNT_W'(free_slots);
        lead = '0;
        stop = 1'b0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if (!din_valid[i]) stop = 1'b1;
            if (!stop) lead = lead + PUSH_CNT_W'(1);
        end
        push_n = (lead < din_ready_ct) ? lead : din_ready_ct;
        if (flush_active) push_n = '0;
    end

    // Commit window: leading valid&done entries from head, capped at POP_WIDTH.
    always_comb begin
        logic stop;
        dout          = '0;
        dout_valid_ct = '0;
        stop          = 1'b0;
        for (int j = 0; j < POP_WIDTH; j++) begin
            if (!(valid_q[pop_idx[j]] && done_q[pop_idx[j]])) stop = 1'b1;
            if (!stop) dout_valid_ct = dout_valid_ct + POP_CNT_W'(1);
            dout[j*DATA_WIDTH +: DATA_WIDTH] = payload_q[pop_idx[j]];
        end
        pop_n = (dout_valid_ct < dout_ready_ct) ? dout_valid_ct : dout_ready_ct;
    end

    // Next-state: completions, then allocations, then commits, then squash.
    always_comb begin
        logic [IDX_W-1:0] c_idx;
        valid_d = valid_q;
        done_d  = done_q;
        c_idx   = '0;
        for (int p = 0; p < CMPLT_PORTS; p++) begin
            c_idx = completed[p*IDX_W +: IDX_W];
            // Stale or out-of-range indices simply do nothing.
            if (cmplt_valid[p] && (c_idx < IDX_W'(ELEMENTS)) && valid_q[c_idx]) begin
                done_d[c_idx] = 1'b1;
            end
        end
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if (PUSH_CNT_W'(i) < push_n) begin
                valid_d[push_idx[i]] = 1'b1;
                done_d[push_idx[i]]  = 1'b0;
            end
        end
        for (int j = 0; j < POP_WIDTH; j++) begin
            if (POP_CNT_W'(j) < pop_n) begin
                valid_d[pop_idx[j]] = 1'b0;
                done_d[pop_idx[j]]  = 1'b0;
            end
        end
        count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        head_d  = head_adv;
        tail_d  = tail_adv;
`ifdef ROB_FLUSH_EN
        if (flush_active) begin
            valid_d = valid_d & keep_mask;
            done_d  = done_d & keep_mask;
            count_d = flush_count - CNT_W'(pop_n);
            tail_d  = flush_tail;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the payload array is cleared too, because dout shows the
            // head payloads unconditionally and must read zero out of reset.
            for (int e = 0; e < ELEMENTS; e++) begin
                payload_q[e] <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < PUSH_WIDTH; i++) begin
                if (PUSH_CNT_W'(i) < push_n) begin
                    payload_q[push_idx[i]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_rob_multi.sv
// -----------------------------------------------------------------------------
// tb_rob_multi
//   Self-checking bench for rob_multi. A reference model (arrays indexed with
//   plain modulo arithmetic, head plus occupancy) predicts every output each
//   cycle; directed scenarios add explicit boundary checks. Flush checks follow
//   the ROB_FLUSH_EN macro the same way the design does.
// -----------------------------------------------------------------------------
module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int DW  = ROB_DATA_WIDTH;
    localparam int PW  = ROB_PUSH_WIDTH;
    localparam int OW  = ROB_POP_WIDTH;
    localparam int CP  = ROB_CMPLT_PORTS;
    localparam int E   = ROB_ELEMENTS;
    localparam int IW  = ROB_IDX_W;
    localparam int PCW = $clog2(PW) + 1;
    localparam int OCW = $clog2(OW) + 1;
`ifdef ROB_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [PW*DW-1:0]  din;
    logic [PW-1:0]     din_valid;
    logic [PCW-1:0]    din_ready_ct;
    logic [PW*IW-1:0]  entry_nums;
    logic [OW*DW-1:0]  dout;
    logic [OCW-1:0]    dout_valid_ct;
    logic [OCW-1:0]    dout_ready_ct;
    logic [CP*IW-1:0]  completed;
    logic [CP-1:0]     cmplt_valid;
    logic              flush;
    logic [IW-1:0]     flush_idx;
    logic [IW:0]       count;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_valid [E];
    bit          m_done  [E];
    logic [DW-1:0] m_pay [E];
    int          m_head;
    int          m_count;

    always #5 clk = ~clk;

    rob_multi dut (
        .clk(clk), .rst(rst),
        .din(din), .din_valid(din_valid), .din_ready_ct(din_ready_ct),
        .entry_nums(entry_nums),
        .dout(dout), .dout_valid_ct(dout_valid_ct), .dout_ready_ct(dout_ready_ct),
        .completed(completed), .cmplt_valid(cmplt_valid),
        .flush(flush), .flush_idx(flush_idx),
        .count(count)
    );

    function automatic int m_ready();
        return (E - m_count < PW) ? (E - m_count) : PW;
    endfunction

    function automatic int m_vct();
        int n = 0;
        while (n < OW && n < m_count && m_valid[(m_head + n) % E] && m_done[(m_head + n) % E])
            n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < E; e++) begin
            m_valid[e] = 1'b0;
            m_done[e]  = 1'b0;
            m_pay[e]   = '0;
        end
        m_head  = 0;
        m_count = 0;
    endtask

    task automatic set_idle();
        din           = '0;
        din_valid     = '0;
        dout_ready_ct = '0;
        completed     = '0;
        cmplt_valid   = '0;
        flush         = 1'b0;
        flush_idx     = '0;
    endtask

    // One clock: compare outputs with the model, predict, advance. Entered and
    // left just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        logic [PW*IW-1:0] exp_en;
        logic [OW*DW-1:0] exp_dout;
        bit nv [E];
        bit nd [E];
        logic [DW-1:0] np [E];
        int rdy, vct, lead, pushes, pops, fage, ncount, e, c;
        bit do_flush;
        #1;
        rdy = m_ready();
        vct = m_vct();
        for (int i = 0; i < PW; i++) exp_en[i*IW +: IW] = IW'((m_head + m_count + i) % E);
        for (int j = 0; j < OW; j++) exp_dout[j*DW +: DW] = m_pay[(m_head + j) % E];
        checks++;
        if (din_ready_ct !== PCW'(rdy)) begin
            errors++; $display("FAIL %s din_ready_ct got %0d want %0d", tag, din_ready_ct, rdy);
        end
        checks++;
        if (dout_valid_ct !== OCW'(vct)) begin
            errors++; $display("FAIL %s dout_valid_ct got %0d want %0d", tag, dout_valid_ct, vct);
        end
        checks++;
        if (count !== (IW+1)'(m_count)) begin
            errors++; $display("FAIL %s count got %0d want %0d", tag, count, m_count);
        end
        checks++;
        if (entry_nums !== exp_en) begin
            errors++; $display("FAIL %s entry_nums got %h want %h", tag, entry_nums, exp_en);
        end
        checks++;
        if (dout !== exp_dout) begin
            errors++; $display("FAIL %s dout got %h want %h", tag, dout, exp_dout);
        end

        lead = 0;
        while (lead < PW && din_valid[lead]) lead++;
        pushes   = (lead < rdy) ? lead : rdy;
        pops     = (int'(dout_ready_ct) < vct) ? int'(dout_ready_ct) : vct;
        do_flush = FLUSH_EN && flush;
        fage     = 0;
        if (do_flush) begin
            pushes = 0;
            assert (m_valid[int'(flush_idx)]) else $error("flush_idx %0d names no valid entry", flush_idx);
            fage = (int'(flush_idx) - m_head + E) % E;
        end
        nv = m_valid;
        nd = m_done;
        np = m_pay;
        for (int p = 0; p < CP; p++) begin
            c = int'(completed[p*IW +: IW]);
            if (cmplt_valid[p] && c < E && m_valid[c]) nd[c] = 1'b1;
        end
        for (int i = 0; i < pushes; i++) begin
            e = (m_head + m_count + i) % E;
            nv[e] = 1'b1; nd[e] = 1'b0; np[e] = din[i*DW +: DW];
        end
        for (int j = 0; j < pops; j++) begin
            e = (m_head + j) % E;
            nv[e] = 1'b0; nd[e] = 1'b0;
        end
        if (do_flush) begin
            for (int k = 0; k < E; k++) begin
                if ((k - m_head + E) % E > fage) begin
                    nv[k] = 1'b0; nd[k] = 1'b0;
                end
            end
            ncount = fage + 1 - pops;
        end else begin
            ncount = m_count + pushes - pops;
        end

        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            m_valid = nv;
            m_done  = nd;
            m_pay   = np;
            m_head  = (m_head + pops) % E;
            m_count = ncount;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        model_reset();
        step("reset");
        rst = 1'b1;
    endtask

    task automatic push_lanes(input int n);
        set_idle();
        for (int i = 0; i < PW; i++) begin
            din[i*DW +: DW] = DW'($urandom());
            din_valid[i]    = (i < n);
        end
        step("push");
        set_idle();
    endtask

    task automatic drain_all();
        int it = 0;
        while (m_count > 0 && it < 60) begin
            set_idle();
            for (int p = 0; p < CP; p++) begin
                if (p < m_count) begin
                    completed[p*IW +: IW] = IW'((m_head + p) % E);
                    cmplt_valid[p]        = 1'b1;
                end
            end
            dout_ready_ct = OCW'(OW);
            step("drain");
            it++;
        end
        set_idle();
    endtask

    task automatic test_reset();
        logic [PW*IW-1:0] exp_en;
        for (int i = 0; i < PW; i++) exp_en[i*IW +: IW] = IW'(i);
        set_idle();
        model_reset();
        #1;
        checks++;
        if (din_ready_ct !== PCW'(PW)) begin
            errors++; $display("FAIL reset din_ready_ct got %0d want %0d", din_ready_ct, PW);
        end
        checks++;
        if (dout_valid_ct !== '0 || count !== '0) begin
            errors++; $display("FAIL reset vct/count got %0d/%0d want 0/0", dout_valid_ct, count);
        end
        checks++;
        if (entry_nums !== exp_en || dout !== '0) begin
            errors++; $display("FAIL reset entry_nums/dout got %h/%h want %h/0", entry_nums, dout, exp_en);
        end
        step("reset_hold");
        rst = 1'b1;
    endtask

    task automatic test_push_commit();
        do_reset();
        din       = {11'h004, 11'h003, 11'h002, 11'h001};
        din_valid = 4'hF;
        step("push4");
        set_idle();
        cmplt_valid   = 3'b011;
        completed     = {IW'(0), IW'(2), IW'(1)};
        dout_ready_ct = 3'd3;
        step("cmplt_1_2");
        cmplt_valid   = 3'b001;
        completed     = {IW'(0), IW'(0), IW'(0)};
        step("cmplt_0");
        set_idle();
        dout_ready_ct = 3'd3;
        #1;
        checks++;
        if (dout_valid_ct !== 3'd3) begin
            errors++; $display("FAIL commit3 dout_valid_ct got %0d want 3", dout_valid_ct);
        end
        step("pop3");
        set_idle();
        #1;
        checks++;
        if (count !== 5'd1 || dout[DW-1:0] !== 11'h004) begin
            errors++; $display("FAIL after_pop3 count/head got %0d/%h want 1/004", count, dout[DW-1:0]);
        end
    endtask

    task automatic test_fill_full();
        int guard = 0;
        while (m_ready() > 0 && guard < 8) begin
            push_lanes(PW);
            guard++;
        end
        #1;
        checks++;
        if (din_ready_ct !== '0 || count !== 5'd15) begin
            errors++; $display("FAIL full ready/count got %0d/%0d want 0/15", din_ready_ct, count);
        end
        set_idle();
        cmplt_valid = 3'b011;
        completed   = {IW'(0), IW'((m_head + 1) % E), IW'(m_head)};
        step("cmplt_head2");
        set_idle();
        dout_ready_ct = 3'd2;
        #1;
        checks++;
        if (dout_valid_ct !== 3'd2 || din_ready_ct !== '0) begin
            errors++; $display("FAIL pop_full vct/ready got %0d/%0d want 2/0", dout_valid_ct, din_ready_ct);
        end
        step("pop2");
        set_idle();
        #1;
        checks++;
        if (din_ready_ct !== 3'd2) begin
            errors++; $display("FAIL after_pop2 din_ready_ct got %0d want 2", din_ready_ct);
        end
        push_lanes(PW);
    endtask

    task automatic test_partial_valid();
        do_reset();
        din_valid = 4'b1011;
        for (int i = 0; i < PW; i++) din[i*DW +: DW] = DW'($urandom());
        step("gap_push");
        set_idle();
        #1;
        checks++;
        if (count !== 5'd2 || entry_nums[IW-1:0] !== IW'(2)) begin
            errors++; $display("FAIL gap_push count/tail got %0d/%0d want 2/2", count, entry_nums[IW-1:0]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            push_lanes(4);
            drain_all();
        end
        push_lanes(1);
        drain_all();
        push_lanes(4);
        push_lanes(1);
        set_idle();
        flush     = 1'b1;
        flush_idx = IW'(0);
        din_valid = 4'b0111;
        step("flush");
        set_idle();
        #1;
`ifdef ROB_FLUSH_EN
        checks++;
        if (count !== 5'd3 || entry_nums[IW-1:0] !== IW'(1)) begin
            errors++; $display("FAIL flush count/tail got %0d/%0d want 3/1", count, entry_nums[IW-1:0]);
        end
`else
        checks++;
        if (count !== 5'd8 || entry_nums[IW-1:0] !== IW'(6)) begin
            errors++; $display("FAIL flush_ignored count/tail got %0d/%0d want 8/6", count, entry_nums[IW-1:0]);
        end
`endif
        drain_all();
    endtask

    task automatic test_random();
        int lo;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            set_idle();
            for (int i = 0; i < PW; i++) din[i*DW +: DW] = DW'($urandom());
            din_valid     = PW'($urandom());
            dout_ready_ct = OCW'($urandom_range(OW, 0));
            for (int p = 0; p < CP; p++) begin
                cmplt_valid[p]        = ($urandom_range(3, 0) != 0);
                completed[p*IW +: IW] = IW'((m_head + $urandom_range(m_count + 1, 0)) % E);
            end
            if (m_count > 0 && $urandom_range(15, 0) == 0) begin
                lo        = (m_vct() > 0) ? m_vct() - 1 : 0;
                flush     = 1'b1;
                flush_idx = IW'((m_head + lo + $urandom_range(m_count - 1 - lo, 0)) % E);
            end
            step("random");
        end
        set_idle();
    endtask

    task automatic test_reset_mid_commit();
        logic [PW*IW-1:0] exp_en;
        for (int i = 0; i < PW; i++) exp_en[i*IW +: IW] = IW'(i);
        do_reset();
        push_lanes(2);
        cmplt_valid = 3'b011;
        completed   = {IW'(0), IW'(1), IW'(0)};
        step("cmplt_01");
        set_idle();
        dout_ready_ct = 3'd2;
        #1;
        checks++;
        if (dout_valid_ct !== 3'd2) begin
            errors++; $display("FAIL pre_reset dout_valid_ct got %0d want 2", dout_valid_ct);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== '0 || dout_valid_ct !== '0 || entry_nums !== exp_en) begin
            errors++; $display("FAIL async_reset count/vct/entry_nums got %0d/%0d/%h want 0/0/%h",
                               count, dout_valid_ct, entry_nums, exp_en);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("post_reset");
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_push_commit();
        test_fill_full();
        test_partial_valid();
        test_flush();
        test_random();
        test_reset_mid_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised successor to the current reorder buffer, tracking old physical aliases from decode to commit.
- Circular buffer with multi-lane in-order allocation and multi-lane in-order commit.
- Accepts completion marks on CMPLT_PORTS independent ports.
- Adds a tail-squash flush for failed terminators, so the frontend can restart without draining.

Parameters:
- DATA_WIDTH, 11, payload bits per entry (old alias pair).
- PUSH_WIDTH, 4, allocation lanes per cycle.
- POP_WIDTH, 3, commit lanes per cycle.
- CMPLT_PORTS, 3, completion ports (alu, mem, term).
- ELEMENTS, 15, entry count; need not be a power of two; must be ≥ PUSH_WIDTH.
- IDX_W, $clog2(ELEMENTS), entry index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din  in  PUSH_WIDTH*DATA_WIDTH  payload per lane; lane 0 is the oldest.
- din_valid  in  PUSH_WIDTH  lane valid bits.
- din_ready_ct  out  $clog2(PUSH_WIDTH)+1  lanes accepted this cycle.
- entry_nums  out  PUSH_WIDTH*IDX_W  index assigned to each lane if pushed this cycle.
- dout  out  POP_WIDTH*DATA_WIDTH  payloads at head; lane 0 is the oldest.
- dout_valid_ct  out  $clog2(POP_WIDTH)+1  consecutive done entries at head.
- dout_ready_ct  in  $clog2(POP_WIDTH)+1  consumer capacity.
- completed  in  CMPLT_PORTS*IDX_W  completing entry index per port.
- cmplt_valid  in  CMPLT_PORTS  completion strobes.
- flush  in  1  squash request.
- flush_idx  in  IDX_W  youngest surviving entry.
- count  out  IDX_W+1  occupied entries.

Behaviour:
- State:
  - Per entry: valid bit, done bit, payload.
  - Pointers: head and tail, each in 0..ELEMENTS-1.
  - count register.
  - All index arithmetic is modulo ELEMENTS, implemented by compare-and-subtract, never by bit truncation.
- Reset (rst=0, async):
  - All valid and done bits clear; head = tail = count = 0.
  - Outputs after reset: din_ready_ct = PUSH_WIDTH, dout_valid_ct = 0, entry_nums = {0,1,..,PUSH_WIDTH-1}, dout = 0.
- Push:
  - din_ready_ct = min(PUSH_WIDTH, ELEMENTS - count), computed from registered count only. Same-cycle pops do not raise it.
  - Accepted count = min(number of contiguous set din_valid bits from lane 0, din_ready_ct).
  - Lanes after the first clear bit are ignored.
  - Accepted lane i writes entry (tail+i) with valid=1, done=0. tail advances by the accepted count.
- Completion:
  - cmplt_valid[p] sets done at index completed[p] on the next edge, only if that entry is valid.
  - Duplicate or stale indices are harmless.
  - Completion is visible in dout_valid_ct one cycle later; there is no same-cycle bypass.
- Commit:
  - dout_valid_ct = number of leading entries from head with valid&done, capped at POP_WIDTH.
  - dout lane j = payload(head+j).
  - Pops = min(dout_valid_ct, dout_ready_ct). Popped entries clear valid/done; head advances by pops.
- count_next = count + pushes - pops. Full (count = ELEMENTS) gives din_ready_ct = 0. Empty gives dout_valid_ct = 0.
- Wrap-around: entry_nums and dout indices wrap past ELEMENTS-1 to 0 within one cycle.
- Flush (ROB_FLUSH_EN):
  - All valid entries strictly younger than flush_idx are invalidated.
  - tail_next = flush_idx+1.
  - Pushes in a flush cycle are dropped.
  - Same-cycle pops still occur.
  - Same-cycle completions apply only to survivors.
  - count_next = ((flush_idx - head) mod ELEMENTS) + 1 - pops.
  - flush_idx must name a valid entry. Behaviour for an invalid flush_idx is undefined; a bench assertion flags it.
- Reset mid-operation discards all state immediately. No partial commits follow.

Optional Feature:
- ROB_FLUSH_EN.
  - Defined: flush/flush_idx behave as above.
  - Undefined: the ports remain but are ignored; the squash logic and flush count path are not built. Recovery then requires drain or reset.

Decomposition:
- Shared package/defines:
  - ROB index width macro, tied to ELEMENTS.
  - PR_ADDR_W-derived payload width (2*PR_ADDR_W+...).
  - Count-width helper.
- One natural sub-module: rob_wrap_add. It is a combinational modular adder, index + k mod ELEMENTS, instanced for entry_nums, dout lanes, pointer advance and flush tail.

Test Plan:
- Reset, then push 4 lanes payload 0x001..0x004 -> entry_nums 0..3; count = 4; dout_valid_ct = 0.
- Complete idx 1 and 2 on ports 0 and 1, then idx 0 a cycle later, with dout_ready_ct = 3 -> dout_valid_ct reaches 3 the cycle after idx 0 completes; 3 pops; head = 3; count = 1.
- Fill to 15 (pushes of 4,4,4,3) -> din_ready_ct = 0 at count 15. Pop 2 -> din_ready_ct = 2 next cycle. Push wraps entry_nums to {0,1}.
- din_valid = 4'b1011 with 4 free -> exactly 2 accepted; tail += 2.
- With head = 13 and entries 13,14,0,1,2 valid, flush with flush_idx = 0 plus 3 pushes in the same cycle -> entries 1,2 invalidated, pushes dropped, tail = 1, count = 3.
- Assert rst low mid-commit with dout_valid_ct = 2 -> next cycle count = 0, dout_valid_ct = 0, entry_nums = 0..3.
